// File: rtl/wb_trace_buffer_if.sv
// Write-back tap and drain port bundle for wb_trace_buffer.
// rd_stamp_o exists only when TRACE_STAMP_EN is defined.
interface wb_trace_buffer_if #(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 4,
    parameter int unsigned STAMP_W = 16
);
    logic               cap_en_i;
    logic               wb_en_i;
    logic [RADDR_W-1:0] wb_addr_i;
    logic [DATA_W-1:0]  wb_data_i;
    logic [PC_W-1:0]    pc_i;

    logic               rd_valid_o;
    logic               rd_ready_i;
    logic [PC_W-1:0]    rd_pc_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0]  rd_data_o;
`ifdef TRACE_STAMP_EN
    logic [STAMP_W-1:0] rd_stamp_o;
`endif

    modport master (
        output cap_en_i, wb_en_i, wb_addr_i, wb_data_i, pc_i, rd_ready_i,
`ifdef TRACE_STAMP_EN
        input  rd_stamp_o,
`endif
        input  rd_valid_o, rd_pc_o, rd_addr_o, rd_data_o
    );

    modport slave (
        input  cap_en_i, wb_en_i, wb_addr_i, wb_data_i, pc_i, rd_ready_i,
`ifdef TRACE_STAMP_EN
        output rd_stamp_o,
`endif
        output rd_valid_o, rd_pc_o, rd_addr_o, rd_data_o
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: circular buffer, PC trigger with post-count, oldest-first drain.
// Optional per-entry cycle stamp enabled by macro TRACE_STAMP_EN.
module wb_trace_buffer #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RADDR_W    = 4,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned STAMP_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_trace_buffer_if.slave      bus,
    input  logic                  trig_arm_i,
    input  logic [PC_W-1:0]       trig_pc_i,
    input  logic [DEPTH_LOG2:0]   post_cnt_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    output logic [1:0]            state_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = DEPTH[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   remaining;
    logic                  overflow;

    logic [PC_W-1:0]       mem_pc   [DEPTH];
    logic [RADDR_W-1:0]    mem_addr [DEPTH];
    logic [DATA_W-1:0]     mem_data [DEPTH];

    logic                  capturing;
    logic                  wr_evt;
    logic                  trig_hit;
    logic                  rd_valid;
    logic                  rd_fire;
    logic [DEPTH_LOG2-1:0] rd_idx;

    assign capturing = (state == ARMED) || (state == POST);
    assign wr_evt    = !trig_arm_i && capturing && bus.cap_en_i && bus.wb_en_i;
    assign trig_hit  = bus.cap_en_i && (bus.pc_i == trig_pc_i);
    assign rd_valid  = (state == DONE) && (count != '0);
    assign rd_fire   = rd_valid && bus.rd_ready_i;
    // count==DEPTH truncates to 0, so the oldest entry is wr_ptr itself
    assign rd_idx    = wr_ptr - count[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
        end else if (trig_arm_i) begin
            state     <= ARMED;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_evt) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count == FULL) overflow <= 1'b1;
                else               count    <= count + 1'b1;
            end
            case (state)
                IDLE: ;
                ARMED: begin
                    if (trig_hit) begin
                        if (post_cnt_i == '0) begin
                            state <= DONE;
                        end else begin
                            remaining <= post_cnt_i;
                            state     <= POST;
                        end
                    end
                end
                POST: begin
                    if (wr_evt) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == 1) state <= DONE;
                    end
                end
                DONE: begin
                    if (rd_fire)          count <= count - 1'b1;
                    else if (count == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_evt) begin
            mem_pc[wr_ptr]   <= bus.pc_i;
            mem_addr[wr_ptr] <= bus.wb_addr_i;
            mem_data[wr_ptr] <= bus.wb_data_i;
        end
    end

    assign bus.rd_valid_o = rd_valid;
    assign bus.rd_pc_o    = rd_valid ? mem_pc[rd_idx]   : '0;
    assign bus.rd_addr_o  = rd_valid ? mem_addr[rd_idx] : '0;
    assign bus.rd_data_o  = rd_valid ? mem_data[rd_idx] : '0;

`ifdef TRACE_STAMP_EN
    logic [STAMP_W-1:0] stamp;
    logic [STAMP_W-1:0] mem_stamp [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stamp <= '0;
        else     stamp <= stamp + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_evt) mem_stamp[wr_ptr] <= stamp;
    end

    assign bus.rd_stamp_o = rd_valid ? mem_stamp[rd_idx] : '0;
`endif

    assign count_o    = count;
    assign overflow_o = overflow;
    assign state_o    = state;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer at DEPTH_LOG2=2 (4 entries).
// Stamp checks compile in only when TRACE_STAMP_EN is defined.
module tb_wb_trace_buffer;
    localparam int unsigned PC_W = 32, DATA_W = 32, RADDR_W = 4, DL2 = 2, STAMP_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             trig_arm;
    logic [PC_W-1:0]  trig_pc;
    logic [DL2:0]     post_cnt;
    logic [DL2:0]     count;
    logic             overflow;
    logic [1:0]       state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [STAMP_W-1:0] cyc;
    logic [STAMP_W-1:0] stamps [3];

    wb_trace_buffer_if #(.PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .STAMP_W(STAMP_W)) bus ();

    wb_trace_buffer #(
        .PC_W(PC_W), .DATA_W(DATA_W), .RADDR_W(RADDR_W), .DEPTH_LOG2(DL2), .STAMP_W(STAMP_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .trig_arm_i(trig_arm), .trig_pc_i(trig_pc), .post_cnt_i(post_cnt),
        .count_o(count), .overflow_o(overflow), .state_o(state)
    );

    always #5 clk = ~clk;

    // reference cycle counter, cleared with reset like the stamp counter
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [PC_W-1:0] pc, input logic [RADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        bus.cap_en_i  = 1'b1;
        bus.wb_en_i   = 1'b1;
        bus.pc_i      = pc;
        bus.wb_addr_i = a;
        bus.wb_data_i = d;
        tick();
        bus.wb_en_i   = 1'b0;
        bus.pc_i      = 32'hFFFF_FFF0;
    endtask

    task automatic arm(input logic [PC_W-1:0] tpc, input logic [DL2:0] pcnt);
        trig_pc  = tpc;
        post_cnt = pcnt;
        trig_arm = 1'b1;
        tick();
        trig_arm = 1'b0;
    endtask

    initial begin
        logic [PC_W-1:0] exp_pc [4];
        exp_pc[0] = 32'h08; exp_pc[1] = 32'h10; exp_pc[2] = 32'h14; exp_pc[3] = 32'h18;

        rst = 1'b1; trig_arm = 1'b0; trig_pc = '0; post_cnt = '0;
        bus.cap_en_i = 1'b0; bus.wb_en_i = 1'b0; bus.pc_i = '0;
        bus.wb_addr_i = '0; bus.wb_data_i = '0; bus.rd_ready_i = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_valid", bus.rd_valid_o, 0);
        check("rst_rd_pc", bus.rd_pc_o, 0);
        tick(); tick();
        rst = 1'b0;

        // idle: writes without arming are ignored
        for (int i = 0; i < 5; i++) wb_write(32'h100 + 32'(i * 4), 4'(i), 32'(i));
        check("idle_count", count, 0);
        check("idle_state", state, 0);
        check("idle_valid", bus.rd_valid_o, 0);

        // basic capture with wrap and overflow
        arm(32'h10, 3'd2);
        check("arm_state", state, 1);
        wb_write(32'h04, 4'd1, 32'h104);
        wb_write(32'h08, 4'd2, 32'h108);
        wb_write(32'h10, 4'd3, 32'hAA);
        check("post_state", state, 2);
        wb_write(32'h14, 4'd5, 32'h114);
        wb_write(32'h18, 4'd6, 32'h118);
        check("done_state", state, 3);
        wb_write(32'h1C, 4'd7, 32'h11C);
        check("done_count", count, 4);
        check("overflow_set", overflow, 1);
        bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus.rd_valid_o, 1);
            check("drain_pc", bus.rd_pc_o, exp_pc[i]);
            if (i == 1) begin
                check("drain_addr", bus.rd_addr_o, 3);
                check("drain_data", bus.rd_data_o, 32'h0000_00AA);
            end
            tick();
        end
        bus.rd_ready_i = 1'b0;
        check("drained_count", count, 0);
        check("drained_valid", bus.rd_valid_o, 0);
        check("drained_pc_zero", bus.rd_pc_o, 0);
        tick();
        check("back_to_idle", state, 0);

        // post_cnt 0: trigger write is the only entry
        arm(32'h00, 3'd0);
        wb_write(32'h00, 4'd9, 32'hDEAD_BEEF);
        check("p0_state", state, 3);
        check("p0_count", count, 1);
        check("p0_pc", bus.rd_pc_o, 0);
        check("p0_data", bus.rd_data_o, 32'hDEAD_BEEF);
        check("p0_overflow", overflow, 0);
        bus.rd_ready_i = 1'b1;
        tick();
        bus.rd_ready_i = 1'b0;
        check("p0_empty", count, 0);
        tick();
        check("p0_idle", state, 0);

        // backpressure
        arm(32'h20, 3'd1);
        wb_write(32'h1C, 4'd1, 32'h21C);
        wb_write(32'h20, 4'd2, 32'h220);
        wb_write(32'h24, 4'd3, 32'h224);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", bus.rd_valid_o, 1);
            check("bp_pc", bus.rd_pc_o, 32'h1C);
            check("bp_data", bus.rd_data_o, 32'h21C);
            check("bp_count", count, 3);
            tick();
        end
        bus.rd_ready_i = 1'b1;
        tick();
        bus.rd_ready_i = 1'b0;
        check("bp_count_after", count, 2);
        check("bp_next_pc", bus.rd_pc_o, 32'h20);
        check("bp_next_addr", bus.rd_addr_o, 2);

        // re-arm mid-drain
        arm(32'h40, 3'd1);
        check("rearm_state", state, 1);
        check("rearm_count", count, 0);
        check("rearm_overflow", overflow, 0);
        check("rearm_valid", bus.rd_valid_o, 0);

        // stall qualifier blocks both write and trigger
        bus.cap_en_i = 1'b0; bus.wb_en_i = 1'b1; bus.pc_i = 32'h40;
        tick();
        bus.wb_en_i = 1'b0; bus.cap_en_i = 1'b1;
        check("stall_state", state, 1);
        check("stall_count", count, 0);
        stamps[0] = cyc; wb_write(32'h44, 4'd4, 32'h344);
        check("st_count1", count, 1);
        tick(); tick();
        stamps[1] = cyc; wb_write(32'h40, 4'd5, 32'h340);
        check("st_post", state, 2);
        stamps[2] = cyc; wb_write(32'h48, 4'd6, 32'h348);
        check("st_done", state, 3);
        check("st_count3", count, 3);
        bus.rd_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("st_pc", bus.rd_pc_o, (i == 0) ? 32'h44 : (i == 1) ? 32'h40 : 32'h48);
`ifdef TRACE_STAMP_EN
            check("st_stamp", bus.rd_stamp_o, stamps[i]);
`endif
            tick();
        end
        bus.rd_ready_i = 1'b0;
`ifdef TRACE_STAMP_EN
        check("st_stamp_zero", bus.rd_stamp_o, 0);
`endif
        check("st_empty", count, 0);

        // asynchronous reset mid-capture
        arm(32'h80, 3'd2);
        wb_write(32'h60, 4'd1, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("areset_state", state, 0);
        check("areset_count", count, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
